// File: rtl/fp8_pkg.sv
// Shared types and constants for the fp8 adder scheduler.
package fp8_pkg;

    localparam int FP8_W   = 8;
    localparam int EXP_W   = 3;
    localparam int FRACT_W = 4;

    typedef struct packed {
        logic               sign;
        logic [EXP_W-1:0]   exp;
        logic [FRACT_W-1:0] fract;
    } fp8_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/fp8_add_sched_if.sv
// Requester, adder and result channels of the fp8 adder scheduler.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface fp8_add_sched_if;
    import fp8_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [FP8_W-1:0] req0_a;
    logic [FP8_W-1:0] req0_b;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [FP8_W-1:0] req1_a;
    logic [FP8_W-1:0] req1_b;
    logic             req1_cin;

    logic [FP8_W-1:0] add_a;
    logic [FP8_W-1:0] add_b;
    logic             add_cin;
    logic [FP8_W-1:0] add_sum;

    logic             res_valid;
    logic             res_ready;
    logic [FP8_W-1:0] res_data;
    logic             res_id;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
        output add_a, add_b, add_cin,
        input  add_sum,
        output res_valid, res_data, res_id,
        input  res_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
        input  add_a, add_b, add_cin,
        output add_sum,
        input  res_valid, res_data, res_id,
        output res_ready
    );

endinterface

// File: rtl/fp8_add_sched_rr_arb2.sv
// Two-way arbiter: round-robin on contention when RR_EN=1, otherwise
// requester 0 has fixed priority.
module rr_arb2 #(
    parameter bit RR_EN = 1'b1
) (
    input  logic [1:0] valid,
    input  logic       ptr,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       ptr_next
);

    // Grant selection and pointer update; the pointer moves to the loser of
    // the current grant so the other requester wins the next contention.
    always_comb begin
        grant    = 2'b00;
        ptr_next = ptr;
        if (valid == 2'b11) begin
            grant = (RR_EN && ptr) ? 2'b10 : 2'b01;
        end else begin
            grant = valid;
        end
        if (RR_EN && advance && (|grant)) begin
            ptr_next = grant[0];
        end
    end

endmodule

// File: rtl/fp8_add_sched.sv
// Shares one combinational fp8 adder between two requesters.
//
//   state | meaning
//   IDLE  | waiting for a request; grant and latch operands on any valid
//   EXEC  | adder driven from operand registers; sum captured at edge
//   DONE  | result presented until the consumer takes it
module fp8_add_sched
    import fp8_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    fp8_add_sched_if.slave   bus,
    output logic [CNT_W-1:0] ops_done
);

    sched_state_t state;
    logic         ptr;
    logic         ptr_next;
    logic [1:0]   valid;
    logic [1:0]   grant;
    logic         advance;
    fp8_t         op_a;
    fp8_t         op_b;
    logic         op_cin;

    assign valid   = {bus.req1_valid, bus.req0_valid};
    assign advance = (state == IDLE) && !rst && (|valid);

    rr_arb2 #(.RR_EN(RR_EN)) u_arb (
        .valid    (valid),
        .ptr      (ptr),
        .advance  (advance),
        .grant    (grant),
        .ptr_next (ptr_next)
    );

    // Ready is a pure function of state, pointer and valids, never res_ready,
    // and is suppressed while reset is held.
    assign bus.req0_ready = advance && grant[0];
    assign bus.req1_ready = advance && grant[1];

    assign bus.add_a   = op_a;
    assign bus.add_b   = op_b;
    assign bus.add_cin = op_cin;

    // Scheduler FSM with registered operand, result and counter outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= 1'b0;
            op_a          <= '0;
            op_b          <= '0;
            op_cin        <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_id    <= 1'b0;
            ops_done      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        op_a       <= fp8_t'(grant[1] ? bus.req1_a : bus.req0_a);
                        op_b       <= fp8_t'(grant[1] ? bus.req1_b : bus.req0_b);
                        op_cin     <= grant[1] ? bus.req1_cin : bus.req0_cin;
                        bus.res_id <= grant[1];
                        ptr        <= ptr_next;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    bus.res_data  <= bus.add_sum;
                    bus.res_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        ops_done      <= ops_done + CNT_W'(1);
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp8_add_sched.sv
// Scoreboard bench for fp8_add_sched: a round-robin instance (16-bit counter)
// under directed and random traffic, and a fixed-priority instance with a
// 2-bit counter for priority and wrap behaviour.
module tb_fp8_add_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Stand-in for the external adder: integer add, or subtract when cin=1.
    function automatic logic [7:0] ref_add(input logic [7:0] a, input logic [7:0] b,
                                           input logic cin);
        return cin ? (a - b) : (a + b);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instance A: round robin, CNT_W=16 ----------------
    fp8_add_sched_if bif_a ();
    logic [15:0] ops_done_a;
    logic       v0 = 0, v1 = 0, c0 = 0, c1 = 0, rr_a = 0;
    logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;

    assign bif_a.req0_valid = v0;
    assign bif_a.req0_a     = a0;
    assign bif_a.req0_b     = b0;
    assign bif_a.req0_cin   = c0;
    assign bif_a.req1_valid = v1;
    assign bif_a.req1_a     = a1;
    assign bif_a.req1_b     = b1;
    assign bif_a.req1_cin   = c1;
    assign bif_a.res_ready  = rr_a;
    assign bif_a.add_sum    = ref_add(bif_a.add_a, bif_a.add_b, bif_a.add_cin);

    fp8_add_sched #(.CNT_W(16), .RR_EN(1'b1)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif_a),
        .ops_done (ops_done_a)
    );

    // ---------------- instance B: fixed priority, CNT_W=2 ----------------
    fp8_add_sched_if bif_b ();
    logic [1:0] ops_done_b;
    logic       bv0 = 0, bv1 = 0, bc0 = 0, bc1 = 0, rr_b = 0;
    logic [7:0] ba0 = 0, bb0 = 0, ba1 = 0, bb1 = 0;

    assign bif_b.req0_valid = bv0;
    assign bif_b.req0_a     = ba0;
    assign bif_b.req0_b     = bb0;
    assign bif_b.req0_cin   = bc0;
    assign bif_b.req1_valid = bv1;
    assign bif_b.req1_a     = ba1;
    assign bif_b.req1_b     = bb1;
    assign bif_b.req1_cin   = bc1;
    assign bif_b.res_ready  = rr_b;
    assign bif_b.add_sum    = ref_add(bif_b.add_a, bif_b.add_b, bif_b.add_cin);

    fp8_add_sched #(.CNT_W(2), .RR_EN(1'b0)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif_b),
        .ops_done (ops_done_b)
    );

    // ---------------- reference model for instance A ----------------
    // phase: 0 free, 1 operation one cycle old, 2 result waiting for consumer
    logic [8:0]  exp_q[$];
    int          phase = 0;
    logic        ptr_m = 0;
    logic [15:0] ops_m = 0;
    logic [7:0]  ea = 0, eb = 0;
    logic        ec = 0;

    // One clock of instance A: check at the falling edge, then advance model.
    task automatic step();
        logic g0, g1;
        g0 = 1'b0;
        g1 = 1'b0;
        @(negedge clk);
        if (rst) begin
            chk("ready0_in_rst", bif_a.req0_ready, 0);
            chk("ready1_in_rst", bif_a.req1_ready, 0);
            if (phase != 0 && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
            phase = 0;
            ptr_m = 1'b0;
            ops_m = '0;
        end else begin
            if (phase == 0) begin
                if (v0 && v1) begin
                    g0 = !ptr_m;
                    g1 = ptr_m;
                end else begin
                    g0 = v0;
                    g1 = v1 && !v0;
                end
            end
            chk("req0_ready", bif_a.req0_ready, g0);
            chk("req1_ready", bif_a.req1_ready, g1);
            chk("res_valid", bif_a.res_valid, (phase == 2));
            chk("ops_done", ops_done_a, ops_m);
            if (phase == 1) begin
                chk("add_a", bif_a.add_a, ea);
                chk("add_b", bif_a.add_b, eb);
                chk("add_cin", bif_a.add_cin, ec);
            end
            if (phase == 0) begin
                if (g0 || g1) begin
                    ea = g1 ? a1 : a0;
                    eb = g1 ? b1 : b0;
                    ec = g1 ? c1 : c0;
                    exp_q.push_back({g1, ref_add(ea, eb, ec)});
                    ptr_m = g0;
                    phase = 1;
                end
            end else if (phase == 1) begin
                phase = 2;
            end else if (rr_a) begin
                phase = 0;
                ops_m = ops_m + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        if (g0) v0 = 1'b0;
        if (g1) v1 = 1'b0;
    endtask

    task automatic new_pair0();
        a0 = 8'($urandom);
        b0 = 8'($urandom);
        c0 = 1'($urandom_range(0, 1));
        v0 = 1'b1;
    endtask

    task automatic new_pair1();
        a1 = 8'($urandom);
        b1 = 8'($urandom);
        c1 = 1'($urandom_range(0, 1));
        v1 = 1'b1;
    endtask

    // Result monitor for instance A: pops the scoreboard on each handshake and
    // checks the result is held while back-pressured.
    bit         held = 0;
    logic [7:0] last_d = 0;
    logic       last_id = 0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst || !bif_a.res_valid) begin
            held = 0;
        end else begin
            if (held) begin
                chk("res_data_stable", bif_a.res_data, last_d);
                chk("res_id_stable", bif_a.res_id, last_id);
            end
            if (bif_a.res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("result_without_request", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_data", bif_a.res_data, e[7:0]);
                    chk("res_id", bif_a.res_id, e[8]);
                end
                held = 0;
            end else begin
                held    = 1;
                last_d  = bif_a.res_data;
                last_id = bif_a.res_id;
            end
        end
    end

    // Instance B: both requesters valid, consumer always ready; requester 0
    // must win every grant and the 2-bit counter must wrap.
    task automatic run_b();
        logic [7:0] bq[$];
        logic       acc, hs;
        int         got;
        got  = 0;
        rr_b = 1'b1;
        ba0 = 8'($urandom); bb0 = 8'($urandom); bc0 = 1'($urandom_range(0, 1)); bv0 = 1'b1;
        ba1 = 8'($urandom); bb1 = 8'($urandom); bc1 = 1'($urandom_range(0, 1)); bv1 = 1'b1;
        for (int c = 0; c < 60 && got < 5; c++) begin
            @(negedge clk);
            acc = bif_b.req0_ready;
            hs  = bif_b.res_valid;
            chk("b_req1_ready", bif_b.req1_ready, 0);
            if (acc) bq.push_back(ref_add(ba0, bb0, bc0));
            if (hs) begin
                if (bq.size() == 0) begin
                    chk("b_result_without_request", 1, 0);
                end else begin
                    chk("b_res_data", bif_b.res_data, bq.pop_front());
                end
                chk("b_res_id", bif_b.res_id, 0);
            end
            @(posedge clk);
            #1;
            if (acc) begin
                ba0 = 8'($urandom); bb0 = 8'($urandom); bc0 = 1'($urandom_range(0, 1));
            end
            if (hs) begin
                got++;
                chk("b_ops_done", ops_done_b, got % 4);
            end
        end
        chk("b_results_seen", got, 5);
        bv0 = 1'b0;
        bv1 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a request pending: no ready may appear, outputs at reset values.
        rst = 1'b1;
        a0 = 8'h55; b0 = 8'h11; v0 = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_add_a", bif_a.add_a, 8'h00);
        chk("rst_add_b", bif_a.add_b, 8'h00);
        chk("rst_add_cin", bif_a.add_cin, 0);
        chk("rst_res_valid", bif_a.res_valid, 0);
        chk("rst_res_data", bif_a.res_data, 8'h00);
        chk("rst_res_id", bif_a.res_id, 0);
        chk("rst_ops_done", ops_done_a, 0);
        chk("rst_ready0", bif_a.req0_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset pulsed while an operation executes.
        a0 = 8'h47; b0 = 8'h19; c0 = 1'b0; v0 = 1'b1; rr_a = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_exec_res_valid", bif_a.res_valid, 0);
        chk("rst_exec_add_a", bif_a.add_a, 8'h00);
        chk("rst_exec_ops_done", ops_done_a, 0);
        step();

        // Single request from requester 0.
        a0 = 8'h34; b0 = 8'h12; c0 = 1'b0; v0 = 1'b1;
        repeat (4) step();
        chk("ops_after_single", ops_done_a, 1);

        // Subtract path from requester 1.
        a1 = 8'hB5; b1 = 8'h23; c1 = 1'b1; v1 = 1'b1;
        repeat (4) step();

        // Both valid continuously, consumer always ready: grants alternate.
        new_pair0();
        new_pair1();
        for (int i = 0; i < 12; i++) begin
            step();
            if (!v0) new_pair0();
            if (!v1) new_pair1();
        end

        // Back-pressure: hold the consumer off for 10 cycles in DONE.
        rr_a = 1'b0;
        for (int i = 0; i < 5 && phase != 2; i++) step();
        chk("backpressure_reached_done", phase, 2);
        repeat (10) step();
        rr_a = 1'b1;
        step();
        if (!v0) new_pair0();
        if (!v1) new_pair1();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step();
            if (!v0 && $urandom_range(0, 2) != 0) new_pair0();
            if (!v1 && $urandom_range(0, 2) != 0) new_pair1();
            rr_a = ($urandom_range(0, 3) != 0);
        end

        // Drain: stop issuing and let everything outstanding complete.
        rr_a = 1'b1;
        for (int i = 0; i < 40 && (v0 || v1 || phase != 0); i++) step();
        step();
        chk("scoreboard_drained", exp_q.size(), 0);

        run_b();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp8_add_sched.md
# fp8_add_sched

Round-robin scheduler that shares the single combinational 8-bit minifloat adder between two operand requesters. Each requester offers an operand pair and an add/subtract select over a valid/ready handshake. The block latches the granted pair, drives the adder from registers, captures the sum, and returns it with the requester ID over a valid/ready result channel. It sits between the operand-capture logic (switch/key front end or a future sequencer) and the adder, replacing the direct register-to-adder wiring.

## Interface
- CNT_W, 16: width of the completed-operation counter.
- RR_EN, 1: 1 = round-robin grant; 0 = fixed priority, requester 0 wins.

- clk  in  1  system clock (CLOCK_50 at top level)
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 pair accepted this cycle
- req0_a, req0_b  in  8 each  operands, {sign[7], exp[6:4], fract[3:0]}
- req0_cin  in  1  carry/subtract select passed to adder cin
- req1_valid / req1_ready / req1_a / req1_b / req1_cin: same as requester 0
- add_a, add_b  out  8 each  registered operands to adder
- add_cin  out  1  registered cin to adder
- add_sum  in  8  combinational adder result, {result_sign, resultexp, resultfract}
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  8  captured sum
- res_id  out  1  requester that issued the result
- ops_done  out  CNT_W  completed-result count

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If no valid, stay.
  - Else grant: if both valid and RR_EN=1, grant requester ptr; else grant the lowest index valid.
  - Assert reqN_ready for the granted N only, combinationally in the same cycle.
  - Latch a, b and cin into the operand registers; latch id.
  - If RR_EN=1, set ptr = ~N.
  - Go to EXEC.
- EXEC: add_* driven from registers. At the clock edge, latch add_sum into res_data. Go to DONE.
- DONE:
  - res_valid=1; res_data and res_id held stable.
  - On res_ready: increment ops_done (wraps modulo 2^CNT_W) and go to IDLE.
- reqN_ready is 0 in EXEC and DONE. No new grant is made until the result is consumed.
- A requester not granted keeps valid high. Its pair must remain stable until its ready pulse.
- Adder output is passed through unmodified; no special-value handling in this block.

## Timing
- Reset values:
  - State IDLE, ptr 0.
  - req0_ready=req1_ready=0 during rst.
  - add_a=add_b=8'h00, add_cin=0.
  - res_valid=0, res_data=8'h00, res_id=0, ops_done=0.
- Accept at cycle T (valid & ready). res_valid rises at T+2.
- Minimum spacing between accepts is 3 cycles, achieved with res_ready held high.
- res_ready may be high before res_valid. The result completes in the first DONE cycle.
- Simultaneous valids alternate grants: 0,1,0,1 starting from ptr=0.
- rst asserted in any state returns to IDLE next edge:
  - In-flight operation dropped, ops_done not incremented.
  - No ready issued during the reset cycle.
- ready depends only on state, ptr and valids. It never depends on res_ready, so there are no combinational loops.

## Structure
- Shared package fp8_pkg:
  - typedef fp8_t as a packed struct {sign, exp[2:0], fract[3:0]}.
  - State enum sched_state_t {IDLE, EXEC, DONE}.
  - Constants FP8_W=8, EXP_W=3, FRACT_W=4.
- One natural sub-module, rr_arb2: 2-way round-robin arbiter.
  - Inputs: valid[1:0], ptr, advance, RR_EN.
  - Outputs: grant one-hot, ptr update.
- The adder stays outside the block; the top level connects add_* and add_sum.

## Test plan
- Reset then single request:
  - Stimulus: req0 a=8'h34, b=8'h12, cin=0 at cycle 5.
  - Response: req0_ready at 5; add_a=8'h34, add_b=8'h12 at 6; res_valid at 7 with res_data = bench adder model, res_id=0; ops_done=1 after handshake.
- Both valid continuously, res_ready=1:
  - Grants alternate 0,1,0,1.
  - Accepts at cycles 0,3,6,9; res_id sequence 0,1,0,1.
  - With RR_EN=0, all four grants go to 0.
- Back-pressure: res_ready low for 10 cycles in DONE:
  - res_valid, res_data and res_id are stable for all 10 cycles.
  - Both reqN_ready stay 0; no second accept until after res_ready.
- Subtract path: req1 cin=1, a=8'hB5, b=8'h23 -> add_cin=1 during EXEC; res_id=1.
- rst pulsed during EXEC -> next cycle IDLE, res_valid=0, ops_done unchanged, add_a=8'h00.
- Counter wrap with CNT_W=2: 5 completed ops -> ops_done reads 1,2,3,0,1.
